randomizer_controller: RTL and testbench
========================================

# randomizer_controller

Sequencer for the serial LFSR/randomizer datapath. It loads a 15-bit seed into the LFSR serially, then steps the LFSR once per accepted payload bit for a burst of `BURST_LEN` bits. It qualifies the randomizer output with `bit_valid` and reports `done` at burst end. It sits between the upstream bit source and the LFSR's `enable`/`load`/`Serial_Input` pins. The randomizer's `data_in` is wired directly from the upstream bit. This block never touches the data.

## Interface
- `BURST_LEN`, 96: payload bits per burst, ≥1.
- `SEED_W`, 15: LFSR length and seed width.
- `DEFAULT_SEED`, 15'b100101010000000: seed used when `use_default_seed`=1.
- `CNT_W`, $clog2(BURST_LEN+1): counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin burst; sampled only in IDLE.
- `seed`  in  SEED_W  burst seed; sampled with `start`.
- `use_default_seed`  in  1  select `DEFAULT_SEED` instead of `seed`; sampled with `start`.
- `in_valid`  in  1  upstream payload bit present on randomizer `data_in`.
- `in_ready`  out  1  controller accepts a payload bit.
- `lfsr_enable`  out  1  drives LFSR `enable`.
- `lfsr_load`  out  1  drives LFSR `load`.
- `lfsr_serial_in`  out  1  drives LFSR `Serial_Input`.
- `bit_valid`  out  1  randomizer `data_out` is a valid payload bit this cycle.
- `bit_count`  out  CNT_W  payload bits accepted in current burst.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE → LOAD when `start`=1. Latch the seed into a shift register (`DEFAULT_SEED` if `use_default_seed`). Clear `bit_count` and the load counter.
- LOAD lasts exactly SEED_W cycles.
  - `lfsr_load`=1 and `lfsr_enable`=1 throughout.
  - `lfsr_serial_in` = seed bit SEED_W-1-k in load cycle k (MSB first).
  - → RUN after cycle SEED_W-1.
- RUN:
  - `in_ready`=1 throughout.
  - Transfer = `in_valid`∧`in_ready`.
  - On a transfer: `lfsr_enable`=1, `bit_valid`=1, `bit_count`+1.
  - When `in_valid`=0: `lfsr_enable`=0, so the PRBS holds and stalls do not consume sequence.
  - → DONE on the transfer that makes `bit_count`=BURST_LEN.
- DONE: `done`=1 for one cycle, then → IDLE. `bit_count` holds BURST_LEN until the next `start`.
- `lfsr_load`=0 and `lfsr_serial_in`=0 outside LOAD. `lfsr_enable`=0 in IDLE and DONE.
- `start` in any state other than IDLE is ignored; there is no queuing.
- `seed`/`use_default_seed` changes after the `start` cycle have no effect on the current burst.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, all outputs 0, `bit_count`=0, internal seed register 0.
- Reset mid-burst aborts the burst immediately and no `done` is issued. The LFSR contents are left undefined; the next burst's LOAD fully reinitialises them.
- Registered (Moore) outputs: `lfsr_load`, `lfsr_serial_in`, `busy`, `done`, `in_ready`, `bit_count`.
- Combinational from `in_valid` and state: `lfsr_enable` in RUN and `bit_valid` only. There is no combinational path from `in_valid` to `in_ready`.
- With `start` sampled at edge 0 and `in_valid` held high:
  - LOAD spans cycles 1–15.
  - RUN spans cycles 16 to 15+BURST_LEN.
  - DONE is cycle 16+BURST_LEN; IDLE follows.
  - Minimum burst latency is SEED_W+BURST_LEN+1 cycles.
- Back-to-back bursts: `start` is accepted in the first IDLE cycle after DONE, giving one idle cycle between bursts.
- `bit_count` never exceeds BURST_LEN and never wraps.

## Structure
- Shared package `randomizer_pkg`:
  - state enum {IDLE, LOAD, RUN, DONE};
  - `SEED_W`=15;
  - `DEFAULT_SEED`;
  - LFSR polynomial constant (1+x^14+x^15) for the bench reference model.
- Single module with no sub-modules. The seed shift register, load counter and bit counter are local.
- Top-level integration instantiates the existing LFSR and Randomizer alongside this block.

## Test plan
- Default-seed load: `start`, `use_default_seed`=1 → during cycles 1–15 `lfsr_serial_in` = 1,0,0,1,0,1,0,1,0,0,0,0,0,0,0, with `lfsr_load`=1 exactly 15 cycles.
- Full burst: stream 96'hACBCD2114DAE1577C6DBF4C9 MSB first with `in_valid`=1 → 96 `bit_valid` cycles. Captured output equals the model input XOR PRBS(seed); `done` pulses at cycle 112.
- Stalls: drop `in_valid` for 3 cycles every 10 bits → output sequence identical to the no-stall run, `lfsr_enable` low during gaps, `done` delayed by the total stall cycles.
- `start` while busy: pulse `start` with a new seed at cycle 40 → ignored; burst completes at cycle 112 with the original PRBS.
- Reset mid-RUN at `bit_count`=50 → all outputs 0 asynchronously, no `done`. A new burst after reset reproduces the full-burst reference exactly.
- `BURST_LEN`=1: one transfer → DONE at cycle 17, `bit_count`=1, `done` single-cycle.

Source files
------------

// File: rtl/randomizer_pkg.sv
// Shared types and constants for the randomizer sequencer and its surroundings.
package randomizer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // LFSR length, equal to the seed width.
    localparam int SEED_W = 15;

    // Seed used when the caller asks for the default sequence.
    localparam logic [SEED_W-1:0] DEFAULT_SEED = 15'b100101010000000;

    // Feedback taps for 1 + x^14 + x^15: the two most significant stages.
    localparam logic [SEED_W-1:0] LFSR_POLY = 15'b110000000000000;

    // Width of the serial-load cycle counter.
    localparam int LD_CNT_W = $clog2(SEED_W);

endpackage

// File: rtl/randomizer_controller.sv
// Sequencer for the serial LFSR/randomizer: serially loads a seed, then
// steps the LFSR once per accepted payload bit for a fixed-length burst.
//
// Handshake: a payload bit transfers in a cycle where in_valid and in_ready
// are both high. in_ready is registered and depends only on state, so there
// is no combinational path from in_valid to in_ready; upstream may hold
// in_valid low for any number of cycles without consuming PRBS sequence.
module randomizer_controller
    import randomizer_pkg::*;
#(
    parameter int BURST_LEN = 96,
    localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic              use_default_seed,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              lfsr_enable,
    output logic              lfsr_load,
    output logic              lfsr_serial_in,
    output logic              bit_valid,
    output logic [CNT_W-1:0]  bit_count,
    output logic              busy,
    output logic              done,
    output ctrl_state_t       dbg_state
);

    localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(BURST_LEN - 1);
    localparam logic [LD_CNT_W-1:0] LAST_LOAD = LD_CNT_W'(SEED_W - 1);

    ctrl_state_t         state;
    ctrl_state_t         next_state;
    logic [SEED_W-1:0]   seed_sr;
    logic [LD_CNT_W-1:0] ld_cnt;
    logic [SEED_W-1:0]   start_seed;
    logic                xfer;

    assign start_seed  = use_default_seed ? DEFAULT_SEED : seed;
    assign xfer        = (state == RUN) && in_valid;
    assign bit_valid   = xfer;
    assign lfsr_enable = (state == LOAD) || xfer;
    assign dbg_state   = state;

    // Next-state decode: load for SEED_W cycles, run until the last bit lands.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (ld_cnt == LAST_LOAD) next_state = RUN;
            RUN:     if (xfer && (bit_count == LAST_BIT)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus the Moore outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            lfsr_load <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
            in_ready  <= (next_state == RUN);
            lfsr_load <= (next_state == LOAD);
        end
    end

    // Seed shifter, load counter and payload bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_sr        <= '0;
            ld_cnt         <= '0;
            bit_count      <= '0;
            lfsr_serial_in <= 1'b0;
        end else begin
            lfsr_serial_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // MSB goes out in the first load cycle; the rest queues up behind it.
                        lfsr_serial_in <= start_seed[SEED_W-1];
                        seed_sr        <= start_seed << 1;
                        ld_cnt         <= '0;
                        bit_count      <= '0;
                    end
                end
                LOAD: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt != LAST_LOAD) begin
                        lfsr_serial_in <= seed_sr[SEED_W-1];
                        seed_sr        <= seed_sr << 1;
                    end
                end
                RUN: begin
                    if (xfer) bit_count <= bit_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_randomizer_controller.sv
// Bench for randomizer_controller: an external LFSR/randomizer driven by the
// controller pins, checked against a PRBS reference built from the seed recurrence.
module tb_randomizer_controller;
    import randomizer_pkg::*;

    localparam int BL = 96;
    localparam int CW = $clog2(BL + 1);
    localparam logic [BL-1:0] PAY = 96'hACBCD2114DAE1577C6DBF4C9;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (BURST_LEN=96) ----------------
    logic              start;
    logic [SEED_W-1:0] seed;
    logic              use_default_seed;
    logic              in_valid;
    logic              in_ready;
    logic              lfsr_enable;
    logic              lfsr_load;
    logic              lfsr_serial_in;
    logic              bit_valid;
    logic [CW-1:0]     bit_count;
    logic              busy;
    logic              done;
    ctrl_state_t       dbg_state;
    logic              data_in;
    logic              data_out;

    randomizer_controller #(.BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .use_default_seed(use_default_seed), .in_valid(in_valid),
        .in_ready(in_ready), .lfsr_enable(lfsr_enable), .lfsr_load(lfsr_load),
        .lfsr_serial_in(lfsr_serial_in), .bit_valid(bit_valid),
        .bit_count(bit_count), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // External LFSR and randomizer as wired in the integration.
    logic [SEED_W-1:0] lfsr_q;
    always @(posedge clk) begin
        if (lfsr_enable)
            lfsr_q <= lfsr_load ? {lfsr_q[SEED_W-2:0], lfsr_serial_in}
                                : {lfsr_q[SEED_W-2:0], ^(lfsr_q & LFSR_POLY)};
    end
    assign data_out = data_in ^ (^(lfsr_q & LFSR_POLY));

    // ---------------- second DUT (BURST_LEN=1) ----------------
    logic              start_1;
    logic [SEED_W-1:0] seed_1;
    logic              use_default_seed_1;
    logic              in_valid_1;
    logic              in_ready_1;
    logic              lfsr_enable_1;
    logic              lfsr_load_1;
    logic              lfsr_serial_in_1;
    logic              bit_valid_1;
    logic [0:0]        bit_count_1;
    logic              busy_1;
    logic              done_1;
    ctrl_state_t       dbg_state_1;

    randomizer_controller #(.BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_1), .seed(seed_1),
        .use_default_seed(use_default_seed_1), .in_valid(in_valid_1),
        .in_ready(in_ready_1), .lfsr_enable(lfsr_enable_1), .lfsr_load(lfsr_load_1),
        .lfsr_serial_in(lfsr_serial_in_1), .bit_valid(bit_valid_1),
        .bit_count(bit_count_1), .busy(busy_1), .done(done_1), .dbg_state(dbg_state_1)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_lfsr_load"}, lfsr_load, 0);
        check({tag, "_serial_in"}, lfsr_serial_in, 0);
        check({tag, "_lfsr_enable"}, lfsr_enable, 0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_bit_count"}, bit_count, 0);
    endtask

    // ---------------- driver: one burst on the main DUT ----------------
    // stall_mode: 0 none, 1 three-cycle gap every 10 bits, 2 random gaps.
    // rst_at >= 0 aborts the burst with reset once that many bits are accepted.
    task automatic run_burst(input logic [SEED_W-1:0] sd, input bit use_def,
                             input logic [BL-1:0] pay, input int stall_mode,
                             input bit busy_start, input int rst_at);
        logic [SEED_W-1:0] eff;
        bit   a [0:SEED_W+BL-1];
        int   cyc, tcount, stalls, gap, last_xfer, load_cycles, done_cyc;
        bit   exp_rdy, xfer_exp, aborted;
        logic exp_bit;

        // Reference PRBS: seed bits MSB first, then a[n] = a[n-15] ^ a[n-14].
        eff = use_def ? DEFAULT_SEED : sd;
        for (int k = 0; k < SEED_W; k++) a[k] = eff[SEED_W-1-k];
        for (int n = SEED_W; n < SEED_W + BL; n++) a[n] = a[n-SEED_W] ^ a[n-SEED_W+1];
        exp_q.delete();
        for (int j = 0; j < BL; j++) exp_q.push_back(pay[BL-1-j] ^ a[SEED_W+j]);

        @(posedge clk); #1;
        start = 1'b1; seed = sd; use_default_seed = use_def; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; seed = 15'($urandom); use_default_seed = ~use_def;

        cyc = 1; tcount = 0; stalls = 0; gap = 0; last_xfer = -10;
        load_cycles = 0; done_cyc = -1; aborted = 1'b0;
        forever begin
            if (stall_mode == 1) begin
                if (gap > 0) begin in_valid = 1'b0; gap--; end
                else in_valid = 1'b1;
            end else if (stall_mode == 2) begin
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b1;
            end
            data_in = (tcount < BL) ? pay[BL-1-tcount] : 1'b0;
            if (busy_start && cyc == 40) begin
                start = 1'b1; seed = ~sd; use_default_seed = 1'b0;
            end else begin
                start = 1'b0;
            end

            exp_rdy  = (cyc >= SEED_W + 1) && (tcount < BL);
            xfer_exp = exp_rdy && in_valid;

            if (rst_at >= 0 && exp_rdy && tcount == rst_at) begin
                check("mid_bit_count", bit_count, rst_at);
                reset = 1'b0;
                #1;
                check_all_zero("mid_rst");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("mid_rst_no_done", done, 0);
                    check("mid_rst_busy", busy, 0);
                end
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end

            @(negedge clk);
            check("lfsr_load", lfsr_load, cyc <= SEED_W);
            check("serial_in", lfsr_serial_in, (cyc <= SEED_W) ? eff[SEED_W-cyc] : 1'b0);
            check("in_ready", in_ready, exp_rdy);
            check("bit_valid", bit_valid, xfer_exp);
            check("lfsr_enable", lfsr_enable, (cyc <= SEED_W) || xfer_exp);
            check("bit_count", bit_count, tcount);
            check("done", done, cyc == last_xfer + 1);
            check("busy", busy, (tcount < BL) || (cyc == last_xfer + 1));
            if (lfsr_load) load_cycles++;
            if (done && done_cyc < 0) done_cyc = cyc;

            if (xfer_exp) begin
                exp_bit = exp_q.pop_front();
                check("data_out", data_out, exp_bit);
                tcount++;
                if (tcount == BL) last_xfer = cyc;
                if (stall_mode == 1 && (tcount % 10) == 0) gap = 3;
            end else if (exp_rdy) begin
                stalls++;
            end

            if (cyc == last_xfer + 2) break;
            if (cyc > 2000) begin
                check("burst_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end

        if (!aborted) begin
            check("done_cycle", done_cyc, SEED_W + 1 + BL + stalls);
            check("load_cycles", load_cycles, SEED_W);
            check("queue_empty", exp_q.size(), 0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // ---------------- driver: BURST_LEN=1 instance ----------------
    task automatic run_single_bit();
        @(posedge clk); #1;
        start_1 = 1'b1; seed_1 = DEFAULT_SEED; use_default_seed_1 = 1'b1; in_valid_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clk);
            check("b1_done", done_1, cyc == 17);
            check("b1_bit_valid", bit_valid_1, cyc == 16);
            check("b1_bit_count", bit_count_1, cyc >= 17);
            check("b1_busy", busy_1, cyc <= 17);
            @(posedge clk); #1;
        end
        in_valid_1 = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [SEED_W-1:0] rs;
        logic [BL-1:0]     rp;

        reset = 1'b0;
        start = 1'b0; seed = '0; use_default_seed = 1'b0; in_valid = 1'b0; data_in = 1'b0;
        start_1 = 1'b0; seed_1 = '0; use_default_seed_1 = 1'b0; in_valid_1 = 1'b0;
        #3;
        check_all_zero("reset");
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_b1_busy", busy_1, 0);
        #20;
        reset = 1'b1;

        run_burst('0, 1'b1, PAY, 0, 1'b0, -1);    // default seed, full burst
        run_burst('0, 1'b1, PAY, 1, 1'b0, -1);    // periodic stalls
        run_burst('0, 1'b1, PAY, 0, 1'b1, -1);    // start while busy
        run_burst('0, 1'b1, PAY, 0, 1'b0, 50);    // reset mid-RUN
        run_burst('0, 1'b1, PAY, 0, 1'b0, -1);    // clean burst after abort
        for (int r = 0; r < 3; r++) begin
            rs = 15'($urandom);
            if (rs == '0) rs = 15'h1;
            rp = {$urandom(), $urandom(), $urandom()};
            run_burst(rs, 1'b0, rp, 2, 1'b0, -1);
        end
        run_single_bit();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
